// File: rtl/fifo_sync_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_sync_ctrl_if
// User-side bundle of the synchronous FIFO controller: write/read requests,
// read data with its valid strobe, and all status flags.
//   master : the FIFO user (drives we/data/re, observes everything else)
//   slave  : the FIFO controller (the opposite directions)
// Parameters WIDTH and DEPTH must match the controller instance.
// -----------------------------------------------------------------------------
interface fifo_sync_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [WIDTH-1:0] data;
  logic             re;
  logic [WIDTH-1:0] q;
  logic             dvld;
  logic             full;
  logic             empty;
  logic             afull;
  logic             aempty;
  logic             overflow;
  logic             underflow;
  logic [AW:0]      rdcnt;

  modport master (
    output we, data, re,
    input  q, dvld, full, empty, afull, aempty, overflow, underflow, rdcnt
  );

  modport slave (
    input  we, data, re,
    output q, dvld, full, empty, afull, aempty, overflow, underflow, rdcnt
  );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_sync_ctrl
// Pointer/flag controller for a synchronous FIFO built around an external
// single-clock RAM with registered read data.
//
// Ports
//   clock    : single rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : user side (fifo_sync_ctrl_if.slave) - we/data/re in,
//              q/dvld/full/empty/afull/aempty/overflow/underflow/rdcnt out
//   wdata    : RAM write data (equals bus.data)
//   waddr    : RAM write address (write pointer)
//   wen      : RAM write enable (write accepted this cycle)
//   raddr    : RAM read address (read pointer)
//   ren      : RAM read enable (read accepted this cycle)
//   rdata    : RAM read data, valid the cycle after ren
//
// Parameters
//   WIDTH, DEPTH (power of two, 4..4096), AFULL_VAL, AEMPTY_VAL,
//   PIPE (0: q = rdata directly; 1: one extra output register stage)
// -----------------------------------------------------------------------------
module fifo_sync_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 128,
  parameter int AFULL_VAL  = 120,
  parameter int AEMPTY_VAL = 8,
  parameter int PIPE       = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  fifo_sync_ctrl_if.slave            bus,
  output logic [WIDTH-1:0]           wdata,
  output logic [$clog2(DEPTH)-1:0]   waddr,
  output logic                       wen,
  output logic [$clog2(DEPTH)-1:0]   raddr,
  output logic                       ren,
  input  logic [WIDTH-1:0]           rdata
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_THR  = (AW+1)'(AFULL_VAL);
  localparam logic [AW:0]   AEMPTY_THR = (AW+1)'(AEMPTY_VAL);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          afull_q;
  logic          aempty_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          wr_acc;
  logic          rd_acc;
  logic          rd_vld;     // rdata holds a freshly read word this cycle

  // Acceptance uses the registered flags, so a write at FULL is rejected even
  // when a read frees a slot in the same cycle, and a read at EMPTY never
  // falls through to the word being written. Gating with reset_n keeps the
  // RAM strobes quiet while reset is held.
  // NOTE: every variable assigned in always_comb gets a default at the top so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_acc    = reset_n & bus.we & ~full_q;
    rd_acc    = reset_n & bus.re & ~empty_q;
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CNT_ONE;
    end
  end

  assign wen   = wr_acc;
  assign ren   = rd_acc;
  assign waddr = wr_ptr;
  assign raddr = rd_ptr;
  assign wdata = bus.data;

  // Flags are derived from count_nxt so they line up with rdcnt in the same
  // cycle. Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_vld      <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count       <= count_nxt;
      full_q      <= (count_nxt == CNT_FULL);
      empty_q     <= (count_nxt == '0);
      afull_q     <= (count_nxt >= AFULL_THR);
      aempty_q    <= (count_nxt <= AEMPTY_THR);
      overflow_q  <= bus.we & full_q;
      underflow_q <= bus.re & empty_q;
      rd_vld      <= rd_acc;
    end
  end

  assign bus.rdcnt     = count;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.afull     = afull_q;
  assign bus.aempty    = aempty_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  generate
    if (PIPE != 0) begin : g_pipe
      // Extra output stage: q only loads on a valid RAM word and otherwise
      // holds, so the consumer sees a stable value between strobes.
      logic [WIDTH-1:0] q_q;
      logic             dvld_q;

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          q_q    <= '0;
          dvld_q <= 1'b0;
        end else begin
          dvld_q <= rd_vld;
          if (rd_vld) q_q <= rdata;
        end
      end

      assign bus.q    = q_q;
      assign bus.dvld = dvld_q;
    end else begin : g_bypass
      assign bus.q    = rdata;
      assign bus.dvld = rd_vld;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_ctrl
// Directed bench for fifo_sync_ctrl. Main instance uses PIPE=1; a second
// instance with PIPE=0 covers the bypass output path. Each instance has a
// small registered-read RAM model on its RAM-side ports.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 1 unit later, registered outputs 1 unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_sync_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // ---------------- PIPE=1 instance ----------------
  fifo_sync_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  logic [WIDTH-1:0] wdata, rdata;
  logic [AW-1:0]    waddr, raddr;
  logic             wen, ren;

  fifo_sync_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_VAL(120), .AEMPTY_VAL(8), .PIPE(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .wdata(wdata), .waddr(waddr), .wen(wen),
    .raddr(raddr), .ren(ren), .rdata(rdata)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

  // ---------------- PIPE=0 instance ----------------
  fifo_sync_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  logic [WIDTH-1:0] wdata0, rdata0;
  logic [AW-1:0]    waddr0, raddr0;
  logic             wen0, ren0;

  fifo_sync_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_VAL(120), .AEMPTY_VAL(8), .PIPE(0)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0),
    .wdata(wdata0), .waddr(waddr0), .wen(wen0),
    .raddr(raddr0), .ren(ren0), .rdata(rdata0)
  );

  logic [WIDTH-1:0] mem0 [DEPTH];
  always_ff @(posedge clock) begin
    if (wen0) mem0[waddr0] <= wdata0;
    if (ren0) rdata0 <= mem0[raddr0];
  end

  // ---------------- reference model (main instance) ----------------
  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_q[$];     // stored words, oldest first
  logic [WIDTH-1:0] rd_exp[$];  // words expected on upcoming dvld strobes
  int               m_cnt = 0;
  logic [AW-1:0]    m_wp = '0;
  logic [AW-1:0]    m_rp = '0;
  logic             m_wacc, m_racc;

  task automatic set_in(input logic w, input logic [WIDTH-1:0] d, input logic r);
    bus.we   = w;
    bus.data = d;
    bus.re   = r;
    m_wacc   = reset_n && w && (m_cnt < DEPTH);
    m_racc   = reset_n && r && (m_cnt > 0);
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset_n) begin
      m_q.delete();
      rd_exp.delete();
      m_cnt = 0;
      m_wp  = '0;
      m_rp  = '0;
    end else begin
      if (m_racc) begin
        rd_exp.push_back(m_q.pop_front());
        m_rp = m_rp + 7'd1;
      end
      if (m_wacc) begin
        m_q.push_back(bus.data);
        m_wp = m_wp + 7'd1;
      end
      m_cnt = m_cnt + int'(m_wacc) - int'(m_racc);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    set_in(1'b1, 32'hDEAD_BEEF, 1'b1);
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", wen); end
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b want 0", ren); end
    step();
    step();
    checks++; if (bus.rdcnt !== 8'd0) begin errors++; $display("FAIL reset_rdcnt: got %0d want 0", bus.rdcnt); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b want 1", bus.aempty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", bus.afull); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", bus.underflow); end
    checks++; if (bus.dvld !== 1'b0) begin errors++; $display("FAIL reset_dvld: got %b want 0", bus.dvld); end
    checks++; if (bus.q !== 32'd0) begin errors++; $display("FAIL reset_q: got %h want 0", bus.q); end
    reset_n = 1'b1;
    set_in(1'b0, '0, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 128; i++) begin
      set_in(1'b1, 32'(i), 1'b0);
      checks++; if (wen !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d]: got %b want 1", i, wen); end
      checks++; if (waddr !== 7'(i)) begin errors++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, waddr, i); end
      checks++; if (wdata !== 32'(i)) begin errors++; $display("FAIL fill_wdata[%0d]: got %h want %h", i, wdata, i); end
      step();
      checks++; if (bus.rdcnt !== 8'(i + 1)) begin errors++; $display("FAIL fill_rdcnt[%0d]: got %0d want %0d", i, bus.rdcnt, i + 1); end
      checks++; if (bus.afull !== (i + 1 >= 120)) begin errors++; $display("FAIL fill_afull[%0d]: got %b want %b", i, bus.afull, (i + 1 >= 120)); end
      checks++; if (bus.full !== (i + 1 == 128)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, (i + 1 == 128)); end
      checks++; if (bus.aempty !== (i + 1 <= 8)) begin errors++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, bus.aempty, (i + 1 <= 8)); end
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b want 0", i, bus.empty); end
    end
    // Two rejected writes in a row: overflow stays high for both.
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 32'hBAD0_0000 + 32'(k), 1'b0);
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL ovf_wen[%0d]: got %b want 0", k, wen); end
      step();
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse[%0d]: got %b want 1", k, bus.overflow); end
      checks++; if (bus.rdcnt !== 8'd128) begin errors++; $display("FAIL ovf_rdcnt[%0d]: got %0d want 128", k, bus.rdcnt); end
    end
    set_in(1'b0, '0, 1'b0);
    step();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 130; k++) begin
      set_in(1'b0, '0, k < 128);
      if (k < 128) begin
        checks++; if (ren !== 1'b1) begin errors++; $display("FAIL drain_ren[%0d]: got %b want 1", k, ren); end
        checks++; if (raddr !== 7'(k)) begin errors++; $display("FAIL drain_raddr[%0d]: got %0d want %0d", k, raddr, k); end
      end
      step();
      if (k < 128) begin
        checks++; if (bus.rdcnt !== 8'(127 - k)) begin errors++; $display("FAIL drain_rdcnt[%0d]: got %0d want %0d", k, bus.rdcnt, 127 - k); end
        checks++; if (bus.aempty !== (127 - k <= 8)) begin errors++; $display("FAIL drain_aempty[%0d]: got %b want %b", k, bus.aempty, (127 - k <= 8)); end
        checks++; if (bus.empty !== (k == 127)) begin errors++; $display("FAIL drain_empty[%0d]: got %b want %b", k, bus.empty, (k == 127)); end
      end
      // First strobe lands two edges after the first accepted read.
      checks++; if (bus.dvld !== (k >= 1 && k <= 128)) begin errors++; $display("FAIL drain_dvld[%0d]: got %b want %b", k, bus.dvld, (k >= 1 && k <= 128)); end
      if (k >= 1) begin
        // After the last strobe q must hold the final word.
        checks++; if (bus.q !== 32'((k <= 128) ? k - 1 : 127)) begin errors++; $display("FAIL drain_q[%0d]: got %h want %h", k, bus.q, (k <= 128) ? k - 1 : 127); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, '0, 1'b1);
      checks++; if (ren !== 1'b0) begin errors++; $display("FAIL udf_ren[%0d]: got %b want 0", k, ren); end
      step();
      checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse[%0d]: got %b want 1", k, bus.underflow); end
      checks++; if (bus.rdcnt !== 8'd0) begin errors++; $display("FAIL udf_rdcnt[%0d]: got %0d want 0", k, bus.rdcnt); end
    end
    set_in(1'b0, '0, 1'b0);
    step();
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b want 0", bus.underflow); end
    checks++; if (bus.dvld !== 1'b0) begin errors++; $display("FAIL udf_dvld: got %b want 0", bus.dvld); end
  endtask

  task automatic test_simul_empty();
    set_in(1'b1, 32'hA5A5_0001, 1'b1);
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL se_wen: got %b want 1", wen); end
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL se_ren: got %b want 0", ren); end
    step();
    checks++; if (bus.rdcnt !== 8'd1) begin errors++; $display("FAIL se_rdcnt: got %0d want 1", bus.rdcnt); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL se_empty: got %b want 0", bus.empty); end
    set_in(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.dvld !== 1'b0) begin errors++; $display("FAIL se_no_dvld[%0d]: got %b want 0", k, bus.dvld); end
    end
    set_in(1'b0, '0, 1'b1);
    step();
    set_in(1'b0, '0, 1'b0);
    step();
    checks++; if (bus.dvld !== 1'b1) begin errors++; $display("FAIL se_dvld: got %b want 1", bus.dvld); end
    checks++; if (bus.q !== 32'hA5A5_0001) begin errors++; $display("FAIL se_q: got %h want a5a50001", bus.q); end
    step();
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 128; i++) begin
      set_in(1'b1, 32'h100 + 32'(i), 1'b0);
      step();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL sf_full_pre: got %b want 1", bus.full); end
    set_in(1'b1, 32'hFFFF_FFFF, 1'b1);
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL sf_wen: got %b want 0", wen); end
    checks++; if (ren !== 1'b1) begin errors++; $display("FAIL sf_ren: got %b want 1", ren); end
    step();
    checks++; if (bus.rdcnt !== 8'd127) begin errors++; $display("FAIL sf_rdcnt: got %0d want 127", bus.rdcnt); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL sf_full: got %b want 0", bus.full); end
    set_in(1'b0, '0, 1'b0);
    step();
    checks++; if (bus.dvld !== 1'b1) begin errors++; $display("FAIL sf_dvld: got %b want 1", bus.dvld); end
    checks++; if (bus.q !== 32'h100) begin errors++; $display("FAIL sf_q: got %h want 00000100", bus.q); end
    step();
  endtask

  task automatic test_wrap();
    int w_wraps = 0;
    int r_wraps = 0;
    int strobes = 0;
    int reads   = 0;
    logic [WIDTH-1:0] exp_q;
    rd_exp.delete();
    for (int c = 0; c < 300; c++) begin
      // First half leans toward reads, second half toward writes.
      logic w, r;
      w = (c < 150) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 70);
      r = (c < 150) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 40);
      set_in(w, $urandom(), r);
      checks++; if (wen !== m_wacc) begin errors++; $display("FAIL wrap_wen[%0d]: got %b want %b", c, wen, m_wacc); end
      checks++; if (ren !== m_racc) begin errors++; $display("FAIL wrap_ren[%0d]: got %b want %b", c, ren, m_racc); end
      if (m_wacc) begin
        checks++; if (waddr !== m_wp) begin errors++; $display("FAIL wrap_waddr[%0d]: got %0d want %0d", c, waddr, m_wp); end
      end
      if (m_racc) begin
        checks++; if (raddr !== m_rp) begin errors++; $display("FAIL wrap_raddr[%0d]: got %0d want %0d", c, raddr, m_rp); end
        reads++;
      end
      if (wen === 1'b1 && waddr === 7'd127) w_wraps++;
      if (ren === 1'b1 && raddr === 7'd127) r_wraps++;
      step();
      checks++; if (bus.rdcnt !== 8'(m_cnt)) begin errors++; $display("FAIL wrap_rdcnt[%0d]: got %0d want %0d", c, bus.rdcnt, m_cnt); end
      if (bus.dvld === 1'b1) begin
        strobes++;
        exp_q = (rd_exp.size() > 0) ? rd_exp.pop_front() : 'x;
        checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL wrap_q[%0d]: got %h want %h", c, bus.q, exp_q); end
      end
    end
    set_in(1'b0, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.dvld === 1'b1) begin
        strobes++;
        exp_q = (rd_exp.size() > 0) ? rd_exp.pop_front() : 'x;
        checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL wrap_tail_q[%0d]: got %h want %h", c, bus.q, exp_q); end
      end
    end
    checks++; if (strobes != reads) begin errors++; $display("FAIL wrap_strobes: got %0d want %0d", strobes, reads); end
    checks++; if (w_wraps == 0) begin errors++; $display("FAIL wrap_waddr_127: got %0d passes want >0", w_wraps); end
    checks++; if (r_wraps == 0) begin errors++; $display("FAIL wrap_raddr_127: got %0d passes want >0", r_wraps); end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    set_in(1'b0, '0, 1'b0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 51; i++) begin
      set_in(1'b1, 32'h2000 + 32'(i), 1'b0);
      step();
    end
    set_in(1'b0, '0, 1'b1);
    step();
    checks++; if (bus.rdcnt !== 8'd50) begin errors++; $display("FAIL mid_rdcnt_pre: got %0d want 50", bus.rdcnt); end
    reset_n = 1'b0;
    set_in(1'b0, '0, 1'b0);
    step();
    checks++; if (bus.dvld !== 1'b0) begin errors++; $display("FAIL mid_dvld: got %b want 0", bus.dvld); end
    checks++; if (bus.rdcnt !== 8'd0) begin errors++; $display("FAIL mid_rdcnt: got %0d want 0", bus.rdcnt); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b want 1", bus.empty); end
    reset_n = 1'b1;
    set_in(1'b1, 32'h3333_4444, 1'b1);
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL mid_wen: got %b want 1", wen); end
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL mid_ren: got %b want 0", ren); end
    checks++; if (waddr !== 7'd0) begin errors++; $display("FAIL mid_waddr: got %0d want 0", waddr); end
    step();
    checks++; if (bus.dvld !== 1'b0) begin errors++; $display("FAIL mid_dvld_post: got %b want 0", bus.dvld); end
    checks++; if (bus.rdcnt !== 8'd1) begin errors++; $display("FAIL mid_rdcnt_post: got %0d want 1", bus.rdcnt); end
    set_in(1'b0, '0, 1'b1);
    checks++; if (raddr !== 7'd0) begin errors++; $display("FAIL mid_raddr: got %0d want 0", raddr); end
    step();
    set_in(1'b0, '0, 1'b0);
    step();
    checks++; if (bus.dvld !== 1'b1) begin errors++; $display("FAIL mid_new_dvld: got %b want 1", bus.dvld); end
    checks++; if (bus.q !== 32'h3333_4444) begin errors++; $display("FAIL mid_new_q: got %h want 33334444", bus.q); end
    step();
  endtask

  task automatic test_pipe0();
    bus0.we = 1'b1; bus0.data = 32'hC0DE_0033; bus0.re = 1'b0;
    #1;
    checks++; if (wen0 !== 1'b1) begin errors++; $display("FAIL p0_wen: got %b want 1", wen0); end
    checks++; if (waddr0 !== 7'd0) begin errors++; $display("FAIL p0_waddr: got %0d want 0", waddr0); end
    @(posedge clock); #1;
    bus0.we = 1'b0; bus0.data = '0; bus0.re = 1'b1;
    #1;
    checks++; if (ren0 !== 1'b1) begin errors++; $display("FAIL p0_ren: got %b want 1", ren0); end
    checks++; if (bus0.dvld !== 1'b0) begin errors++; $display("FAIL p0_dvld_early: got %b want 0", bus0.dvld); end
    @(posedge clock); #1;
    bus0.re = 1'b0;
    checks++; if (bus0.dvld !== 1'b1) begin errors++; $display("FAIL p0_dvld: got %b want 1", bus0.dvld); end
    checks++; if (bus0.q !== 32'hC0DE_0033) begin errors++; $display("FAIL p0_q: got %h want c0de0033", bus0.q); end
    @(posedge clock); #1;
    checks++; if (bus0.dvld !== 1'b0) begin errors++; $display("FAIL p0_dvld_late: got %b want 0", bus0.dvld); end
    checks++; if (bus0.rdcnt !== 8'd0) begin errors++; $display("FAIL p0_rdcnt: got %0d want 0", bus0.rdcnt); end
  endtask

  initial begin
    reset_n   = 1'b0;
    bus0.we   = 1'b0;
    bus0.data = '0;
    bus0.re   = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_simul_empty();
    test_simul_full();
    test_wrap();
    test_reset_mid();
    test_pipe0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
